// File: rtl/ga_pkg.sv
// ga_pkg: shared types for the geometric-algebra datapath.
//   ga_multivector_t    - packed 2D multivector (scalar, e1, e2, e12), 16 bits each
//   ga_funct_e          - ALU operation select
//   ga_dispatch_state_e - command dispatcher FSM states
package ga_pkg;

  localparam int unsigned GA_COMP_W = 16;

  typedef struct packed {
    logic [GA_COMP_W-1:0] s;
    logic [GA_COMP_W-1:0] e1;
    logic [GA_COMP_W-1:0] e2;
    logic [GA_COMP_W-1:0] e12;
  } ga_multivector_t;

  typedef enum logic [2:0] {
    GA_ADD     = 3'd0,
    GA_SUB     = 3'd1,
    GA_GEOM    = 3'd2,
    GA_OUTER   = 3'd3,
    GA_INNER   = 3'd4,
    GA_REVERSE = 3'd5
  } ga_funct_e;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_WAIT = 2'd1,
    D_HOLD = 2'd2
  } ga_dispatch_state_e;

endpackage

// File: rtl/ga_cmd_fifo.sv
// ga_cmd_fifo: DEPTH-entry command FIFO with wrapping read/write pointers.
//   clk_i, rst_ni       - clock, asynchronous active-low reset
//   push_i / wdata_i    - write strobe and payload (caller must not push when full)
//   pop_i / rdata_o     - read strobe and head-of-queue payload (caller must not pop when empty)
//   count_o             - number of occupied entries, 0..DEPTH
//   full_o, empty_o     - occupancy flags
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
// Payload storage has no reset; only pointers and count are cleared.
module ga_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ga_alu_dispatch.sv
// ga_alu_dispatch: queues GA ALU commands and issues them one at a time,
// returning each ALU result with the originating command's tag.
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   cmd_*                    - command input handshake {a, b, funct, tag}
//   alu_*                    - ALU issue handshake, done pulse, result and error
//   rsp_*                    - response output handshake {result, tag, error}
//   busy_o, count_o          - activity flag and FIFO occupancy
//   perf_issued_o/stall_o    - saturating performance counters
// Build option: define GA_DISPATCH_PERF_EN to implement the perf counters;
// otherwise they read constant zero and no counter flops exist.
module ga_alu_dispatch
  import ga_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  ga_multivector_t        cmd_a_i,
  input  ga_multivector_t        cmd_b_i,
  input  ga_funct_e              cmd_funct_i,
  input  logic [TAG_W-1:0]       cmd_tag_i,
  output logic                   alu_valid_o,
  input  logic                   alu_ready_i,
  output ga_multivector_t        alu_a_o,
  output ga_multivector_t        alu_b_o,
  output ga_funct_e              alu_op_o,
  input  ga_multivector_t        alu_result_i,
  input  logic                   alu_done_i,
  input  logic                   alu_error_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output ga_multivector_t        rsp_result_o,
  output logic [TAG_W-1:0]       rsp_tag_o,
  output logic                   rsp_error_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [31:0]            perf_issued_o,
  output logic [31:0]            perf_stall_o
);

  localparam int unsigned MV_W = $bits(ga_multivector_t);
  localparam int unsigned FN_W = $bits(ga_funct_e);
  localparam int unsigned PW   = 2 * MV_W + FN_W + TAG_W;

  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [PW-1:0]          fifo_wdata;
  logic [PW-1:0]          fifo_rdata;

  ga_multivector_t        head_a;
  ga_multivector_t        head_b;
  logic [FN_W-1:0]        head_funct;
  logic [TAG_W-1:0]       head_tag;

  ga_dispatch_state_e     state_q, state_d;
  logic [TAG_W-1:0]       inflight_tag_q, inflight_tag_d;
  ga_multivector_t        rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]       rsp_tag_q, rsp_tag_d;
  logic                   rsp_error_q, rsp_error_d;

  // Ready depends only on occupancy, so a full FIFO stays closed even
  // in a cycle where the head is being popped.
  assign cmd_ready_o = !fifo_full;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign fifo_wdata  = {cmd_a_i, cmd_b_i, cmd_funct_i, cmd_tag_i};

  ga_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_a, head_b, head_funct, head_tag} = fifo_rdata;
  assign alu_a_o  = head_a;
  assign alu_b_o  = head_b;
  assign alu_op_o = ga_funct_e'(head_funct);

  always_comb begin
    state_d        = state_q;
    inflight_tag_d = inflight_tag_q;
    rsp_result_d   = rsp_result_q;
    rsp_tag_d      = rsp_tag_q;
    rsp_error_d    = rsp_error_q;
    alu_valid_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    pop            = 1'b0;
    unique case (state_q)
      D_IDLE: begin
        alu_valid_o = !fifo_empty;
        if (!fifo_empty && alu_ready_i) begin
          pop            = 1'b1;
          inflight_tag_d = head_tag;
          state_d        = D_WAIT;
        end
      end
      D_WAIT: begin
        if (alu_done_i) begin
          rsp_result_d = alu_result_i;
          rsp_error_d  = alu_error_i;
          rsp_tag_d    = inflight_tag_q;
          state_d      = D_HOLD;
        end
      end
      D_HOLD: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= D_IDLE;
      inflight_tag_q <= '0;
      rsp_result_q   <= '0;
      rsp_tag_q      <= '0;
      rsp_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      inflight_tag_q <= inflight_tag_d;
      rsp_result_q   <= rsp_result_d;
      rsp_tag_q      <= rsp_tag_d;
      rsp_error_q    <= rsp_error_d;
    end
  end

  assign rsp_result_o = rsp_result_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign rsp_error_o  = rsp_error_q;
  assign count_o      = fifo_count;
  assign busy_o       = (state_q != D_IDLE) || (fifo_count != '0);

`ifdef GA_DISPATCH_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall;

  always_comb begin
    stall         = (alu_valid_o && !alu_ready_i) || (rsp_valid_o && !rsp_ready_i);
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (pop && (perf_issued_q != '1))  perf_issued_d = perf_issued_q + 32'd1;
    if (stall && (perf_stall_q != '1)) perf_stall_d  = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued_o = perf_issued_q;
  assign perf_stall_o  = perf_stall_q;
`else
  assign perf_issued_o = '0;
  assign perf_stall_o  = '0;
`endif

endmodule

// File: tb/tb_ga_alu_dispatch.sv
// tb_ga_alu_dispatch: directed self-checking bench for ga_alu_dispatch
// (DEPTH = 4, TAG_W = 4). The bench plays the ALU and the response sink.
module tb_ga_alu_dispatch;
  import ga_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;
`ifdef GA_DISPATCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  ga_multivector_t cmd_a_i;
  ga_multivector_t cmd_b_i;
  ga_funct_e       cmd_funct_i;
  logic [TAG_W-1:0] cmd_tag_i;
  logic            alu_valid_o;
  logic            alu_ready_i;
  ga_multivector_t alu_a_o;
  ga_multivector_t alu_b_o;
  ga_funct_e       alu_op_o;
  ga_multivector_t alu_result_i;
  logic            alu_done_i;
  logic            alu_error_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  ga_multivector_t rsp_result_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic            rsp_error_o;
  logic            busy_o;
  logic [$clog2(DEPTH):0] count_o;
  logic [31:0]     perf_issued_o;
  logic [31:0]     perf_stall_o;

  int n_tests = 0;
  int n_fail  = 0;

  ga_multivector_t mv_a = 64'h0001_0002_0003_0004;
  ga_multivector_t mv_b = 64'h0010_0020_0030_0040;
  ga_multivector_t mv_r = 64'h0011_0022_0033_0044;
  ga_multivector_t mv_x = 64'hDEAD_BEEF_CAFE_F00D;

  ga_alu_dispatch #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_a_i       (cmd_a_i),
    .cmd_b_i       (cmd_b_i),
    .cmd_funct_i   (cmd_funct_i),
    .cmd_tag_i     (cmd_tag_i),
    .alu_valid_o   (alu_valid_o),
    .alu_ready_i   (alu_ready_i),
    .alu_a_o       (alu_a_o),
    .alu_b_o       (alu_b_o),
    .alu_op_o      (alu_op_o),
    .alu_result_i  (alu_result_i),
    .alu_done_i    (alu_done_i),
    .alu_error_i   (alu_error_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_result_o  (rsp_result_o),
    .rsp_tag_o     (rsp_tag_o),
    .rsp_error_o   (rsp_error_o),
    .busy_o        (busy_o),
    .count_o       (count_o),
    .perf_issued_o (perf_issued_o),
    .perf_stall_o  (perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    cmd_valid_i  = 1'b0;
    cmd_a_i      = '0;
    cmd_b_i      = '0;
    cmd_funct_i  = GA_ADD;
    cmd_tag_i    = '0;
    alu_ready_i  = 1'b0;
    alu_result_i = '0;
    alu_done_i   = 1'b0;
    alu_error_i  = 1'b0;
    rsp_ready_i  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if ({cmd_ready_o, alu_valid_o, rsp_valid_o, busy_o} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 1000", {cmd_ready_o, alu_valid_o, rsp_valid_o, busy_o}); end
    n_tests++; if ({rsp_result_o, rsp_tag_o, rsp_error_o} !== '0) begin
      n_fail++; $display("FAIL reset_rsp: got %h/%h/%b want 0", rsp_result_o, rsp_tag_o, rsp_error_o); end
    n_tests++; if (count_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_tests++; if ({perf_issued_o, perf_stall_o} !== 64'd0) begin
      n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_issued_o, perf_stall_o); end
  endtask

  task automatic test_single();
    do_reset();
    alu_ready_i = 1'b1; rsp_ready_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_a_i = mv_a; cmd_b_i = mv_b; cmd_funct_i = GA_ADD; cmd_tag_i = 4'd3;
    #1;
    n_tests++; if ({cmd_ready_o, alu_valid_o} !== 2'b10) begin
      n_fail++; $display("FAIL single_c0: ready/valid got %b want 10", {cmd_ready_o, alu_valid_o}); end
    tick();
    cmd_valid_i = 1'b0;
    #1;
    n_tests++; if (alu_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL single_c1_valid: got %b want 1", alu_valid_o); end
    n_tests++; if ({alu_a_o, alu_b_o, alu_op_o} !== {mv_a, mv_b, GA_ADD}) begin
      n_fail++; $display("FAIL single_c1_operands: got %h %h %0d want %h %h %0d", alu_a_o, alu_b_o, alu_op_o, mv_a, mv_b, GA_ADD); end
    tick();
    #1;
    n_tests++; if ({alu_valid_o, rsp_valid_o, busy_o} !== 3'b001) begin
      n_fail++; $display("FAIL single_c2: valid/rsp/busy got %b want 001", {alu_valid_o, rsp_valid_o, busy_o}); end
    tick();
    alu_done_i = 1'b1; alu_result_i = mv_r;
    tick();
    alu_done_i = 1'b0;
    #1;
    n_tests++; if ({rsp_valid_o, rsp_tag_o, rsp_result_o, rsp_error_o} !== {1'b1, 4'd3, mv_r, 1'b0}) begin
      n_fail++; $display("FAIL single_c4_rsp: got v%b t%0d r%h e%b want v1 t3 r%h e0", rsp_valid_o, rsp_tag_o, rsp_result_o, rsp_error_o, mv_r); end
    n_tests++; if (perf_issued_o !== (PERF ? 32'd1 : 32'd0)) begin
      n_fail++; $display("FAIL single_perf_issued: got %0d want %0d", perf_issued_o, PERF ? 1 : 0); end
    tick();
    #1;
    n_tests++; if ({rsp_valid_o, busy_o} !== 2'b00) begin
      n_fail++; $display("FAIL single_c5_idle: rsp/busy got %b want 00", {rsp_valid_o, busy_o}); end
  endtask

  task automatic test_full();
    do_reset();
    alu_ready_i = 1'b0; rsp_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_valid_i = 1'b1; cmd_tag_i = TAG_W'(i); cmd_a_i = {4{16'(i + 1)}};
      #1;
      n_tests++; if (cmd_ready_o !== (i < 4)) begin
        n_fail++; $display("FAIL full_ready_%0d: got %b want %b", i, cmd_ready_o, (i < 4)); end
      if (i < 4) tick();
    end
    n_tests++; if (count_o !== 3'd4) begin
      n_fail++; $display("FAIL full_count: got %0d want 4", count_o); end
    n_tests++; if ({alu_valid_o, alu_a_o} !== {1'b1, {4{16'd1}}}) begin
      n_fail++; $display("FAIL full_head: got v%b a%h want v1 a0001000100010001", alu_valid_o, alu_a_o); end
    n_tests++; if (perf_stall_o !== (PERF ? 32'd3 : 32'd0)) begin
      n_fail++; $display("FAIL full_perf_stall: got %0d want %0d", perf_stall_o, PERF ? 3 : 0); end
    tick(); tick();
    #1;
    n_tests++; if ({cmd_ready_o, count_o} !== {1'b0, 3'd4}) begin
      n_fail++; $display("FAIL full_held: ready/count got %b/%0d want 0/4", cmd_ready_o, count_o); end
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    alu_ready_i = 1'b1; rsp_ready_i = 1'b0;
    cmd_valid_i = 1'b1; cmd_tag_i = 4'd5; cmd_a_i = mv_a;
    tick();
    cmd_tag_i = 4'd6; cmd_a_i = mv_b;
    #1;
    n_tests++; if ({alu_valid_o, alu_a_o} !== {1'b1, mv_a}) begin
      n_fail++; $display("FAIL hold_issue: got v%b a%h want v1 a%h", alu_valid_o, alu_a_o, mv_a); end
    tick();
    cmd_valid_i = 1'b0;
    tick();
    alu_done_i = 1'b1; alu_result_i = mv_r;
    tick();
    alu_done_i = 1'b0; alu_result_i = mv_x;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_tests++; if ({rsp_valid_o, rsp_tag_o, rsp_result_o, alu_valid_o} !== {1'b1, 4'd5, mv_r, 1'b0}) begin
        n_fail++; $display("FAIL hold_stable_%0d: got v%b t%0d r%h alu_v%b want v1 t5 r%h alu_v0", k, rsp_valid_o, rsp_tag_o, rsp_result_o, alu_valid_o, mv_r); end
      tick();
    end
    rsp_ready_i = 1'b1;
    #1;
    n_tests++; if ({rsp_valid_o, alu_valid_o} !== 2'b10) begin
      n_fail++; $display("FAIL hold_release: rsp/alu valid got %b want 10", {rsp_valid_o, alu_valid_o}); end
    n_tests++; if (perf_stall_o !== (PERF ? 32'd10 : 32'd0)) begin
      n_fail++; $display("FAIL hold_perf_stall: got %0d want %0d", perf_stall_o, PERF ? 10 : 0); end
    tick();
    #1;
    n_tests++; if ({rsp_valid_o, alu_valid_o, alu_a_o} !== {1'b0, 1'b1, mv_b}) begin
      n_fail++; $display("FAIL hold_next_issue: got rsp%b alu%b a%h want rsp0 alu1 a%h", rsp_valid_o, alu_valid_o, alu_a_o, mv_b); end
  endtask

  task automatic test_push_pop();
    do_reset();
    alu_ready_i = 1'b0; rsp_ready_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_tag_i = 4'd0;
    tick();
    cmd_tag_i = 4'd1;
    tick();
    cmd_tag_i = 4'd2; alu_ready_i = 1'b1;
    #1;
    n_tests++; if ({count_o, alu_valid_o, cmd_ready_o} !== {3'd2, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL pushpop_before: count/valid/ready got %0d/%b/%b want 2/1/1", count_o, alu_valid_o, cmd_ready_o); end
    tick();
    cmd_valid_i = 1'b0; alu_ready_i = 1'b0;
    #1;
    n_tests++; if (count_o !== 3'd2) begin
      n_fail++; $display("FAIL pushpop_after: count got %0d want 2", count_o); end
  endtask

  task automatic test_wrap();
    int np = 0;
    int nr = 0;
    int issue_cyc = -10;
    logic pushed;
    logic issued;
    do_reset();
    alu_ready_i = 1'b1; rsp_ready_i = 1'b1;
    for (int cyc = 0; cyc < 200 && nr < 10; cyc++) begin
      cmd_valid_i  = (np < 10);
      cmd_tag_i    = TAG_W'(np);
      cmd_a_i      = {4{16'(np)}};
      alu_done_i   = (cyc == issue_cyc + 2);
      alu_result_i = {4{16'(nr + 256)}};
      #1;
      if (rsp_valid_o) begin
        n_tests++; if ({rsp_tag_o, rsp_result_o} !== {TAG_W'(nr), {4{16'(nr + 256)}}}) begin
          n_fail++; $display("FAIL wrap_rsp_%0d: got t%0d r%h want t%0d r%h", nr, rsp_tag_o, rsp_result_o, nr, {4{16'(nr + 256)}}); end
        nr++;
      end
      pushed = cmd_valid_i && cmd_ready_o;
      issued = alu_valid_o && alu_ready_i;
      tick();
      if (pushed) np++;
      if (issued) issue_cyc = cyc;
    end
    cmd_valid_i = 1'b0; alu_done_i = 1'b0;
    n_tests++; if (nr !== 10) begin
      n_fail++; $display("FAIL wrap_complete: got %0d responses want 10 within budget", nr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alu_ready_i = 1'b0; rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid_i = 1'b1; cmd_tag_i = TAG_W'(i + 8);
      tick();
    end
    cmd_valid_i = 1'b0; alu_ready_i = 1'b1;
    #1;
    n_tests++; if (alu_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_issue: got %b want 1", alu_valid_o); end
    tick();
    alu_ready_i = 1'b0;
    #1;
    n_tests++; if ({count_o, alu_valid_o, busy_o} !== {3'd3, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rstmid_wait: count/valid/busy got %0d/%b/%b want 3/0/1", count_o, alu_valid_o, busy_o); end
    rst_ni = 1'b0;
    #1;
    n_tests++; if ({cmd_ready_o, alu_valid_o, rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_error_o, busy_o, count_o}
                   !== {1'b1, 1'b0, 1'b0, 64'd0, 4'd0, 1'b0, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL rstmid_outputs: rdy%b av%b rv%b r%h t%0d e%b busy%b cnt%0d want 1 0 0 0 0 0 0 0",
                         cmd_ready_o, alu_valid_o, rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_error_o, busy_o, count_o); end
    n_tests++; if ({perf_issued_o, perf_stall_o} !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_perf: got %0d/%0d want 0/0", perf_issued_o, perf_stall_o); end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    alu_done_i = 1'b1; alu_result_i = mv_x; alu_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_tests++; if ({rsp_valid_o, alu_valid_o} !== 2'b00) begin
        n_fail++; $display("FAIL rstmid_quiet_%0d: rsp/alu valid got %b want 00", k, {rsp_valid_o, alu_valid_o}); end
      tick();
      alu_done_i = 1'b0;
    end
  endtask

  task automatic test_spurious_done();
    do_reset();
    alu_ready_i = 1'b1; rsp_ready_i = 1'b1;
    alu_done_i = 1'b1; alu_error_i = 1'b1; alu_result_i = mv_x;
    #1;
    n_tests++; if (rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL spur_c0: rsp_valid got %b want 0", rsp_valid_o); end
    tick();
    alu_done_i = 1'b0; alu_error_i = 1'b0;
    cmd_valid_i = 1'b1; cmd_tag_i = 4'd7; cmd_a_i = mv_a;
    #1;
    n_tests++; if ({rsp_valid_o, busy_o} !== 2'b00) begin
      n_fail++; $display("FAIL spur_ignored: rsp/busy got %b want 00", {rsp_valid_o, busy_o}); end
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    alu_done_i = 1'b1; alu_error_i = 1'b1; alu_result_i = mv_r;
    tick();
    alu_done_i = 1'b0; alu_error_i = 1'b0; rsp_ready_i = 1'b0;
    #1;
    n_tests++; if ({rsp_valid_o, rsp_error_o, rsp_tag_o, rsp_result_o} !== {1'b1, 1'b1, 4'd7, mv_r}) begin
      n_fail++; $display("FAIL spur_error_rsp: got v%b e%b t%0d r%h want v1 e1 t7 r%h", rsp_valid_o, rsp_error_o, rsp_tag_o, rsp_result_o, mv_r); end
    alu_done_i = 1'b1; alu_result_i = mv_x;
    tick();
    alu_done_i = 1'b0;
    #1;
    n_tests++; if ({rsp_result_o, rsp_error_o} !== {mv_r, 1'b1}) begin
      n_fail++; $display("FAIL spur_hold_done: got r%h e%b want r%h e1", rsp_result_o, rsp_error_o, mv_r); end
    rsp_ready_i = 1'b1;
    tick();
    #1;
    n_tests++; if (rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL spur_drain: rsp_valid got %b want 0", rsp_valid_o); end
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_hold();
    test_push_pop();
    test_wrap();
    test_reset_mid();
    test_spurious_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
